// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule definitions: widths, rcon start value, phase encoding.
package aes_key_pkg;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 192;

  // Rcon consumed by w[48], the first rcon-bearing word met walking backwards.
  localparam logic [7:0] RCON_LAST = 8'h80;

  // Position of the 4-word step relative to the 6-word rcon period.
  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2
  } phase_e;
endpackage

// File: rtl/inv_expand192_if.sv
// Control/data bundle between a decryption round controller and the inverse
// AES-192 key expander.
interface inv_expand192_if;
  import aes_key_pkg::*;

  logic               load;
  logic [KEY_W-1:0]   lastKey;
  logic               advance;
  logic [BLOCK_W-1:0] roundKey;
  logic [3:0]         roundIdx;
  logic               keyValid;
  logic               last;

  modport master (
    output load, lastKey, advance,
    input  roundKey, roundIdx, keyValid, last
  );

  modport slave (
    input  load, lastKey, advance,
    output roundKey, roundIdx, keyValid, last
  );
endinterface

// File: rtl/inv_galoismult.sv
// Divide by x in GF(2^8) (AES polynomial): undoes one xtime, so it walks the
// Rcon sequence backwards (80, 40, ..., 01).
module inv_galoismult (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = a_i[0] ? (((a_i ^ 8'h1b) >> 1) | 8'h80) : (a_i >> 1);
endmodule

// File: rtl/rotate.sv
// Left rotate of an N-element vector of W-bit elements by SHIFT elements.
// With N=4, W=8, SHIFT=1 this is the AES RotWord.
module rotate #(
  parameter int SHIFT = 1,
  parameter int N     = 4,
  parameter int W     = 8
) (
  input  logic [N*W-1:0] in_i,
  output logic [N*W-1:0] out_o
);
  assign out_o = {in_i[N*W-SHIFT*W-1:0], in_i[N*W-1 -: SHIFT*W]};
endmodule

// File: rtl/subword.sv
// AES SubWord: four parallel S-boxes. Each S-box is the GF(2^8) inverse
// (x^254) followed by the AES affine transform.
module subword (
  input  logic [31:0] in_i,
  output logic [31:0] out_o
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 = prod x^(2^i), i=1..7; maps 0 to 0 as AES requires.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar b = 0; b < 4; b++) begin : g_sb
    assign out_o[8*b +: 8] = sbox(in_i[8*b +: 8]);
  end
endmodule

// File: rtl/inv_expand192.sv
// AES-192 inverse key expansion. Holds a 6-word window w[k..k+5] and, per
// advance, derives the 4 older words w[k-4..k-1] from it in one cycle. The
// low 4 window words are the current round key (12 down to 0).
module inv_expand192 #(
  parameter int unsigned NROUNDS   = 12,
  parameter logic [7:0]  RCON_LAST = aes_key_pkg::RCON_LAST
) (
  input logic            clk,
  input logic            reset,
  inv_expand192_if.slave bus
);
  import aes_key_pkg::WORD_W;
  import aes_key_pkg::BLOCK_W;
  import aes_key_pkg::KEY_W;
  import aes_key_pkg::phase_e;
  import aes_key_pkg::P0;
  import aes_key_pkg::P1;
  import aes_key_pkg::P2;

  localparam logic [3:0] IDX_FIRST = 4'(NROUNDS);

  logic [KEY_W-1:0]        win_q, win_d;
  logic [7:0]              rcon_q, rcon_div;
  phase_e                  phase_q;
  logic [3:0]              idx_q;
  logic                    vld_q;
  logic                    step;

  // wv[5] is w[k] (oldest), wv[0] is w[k+5].
  logic [5:0][WORD_W-1:0]  wv;
  // gin[j]/nw[3-j]: f-input and result for new word j = w[k-4+j].
  logic [3:0][WORD_W-1:0]  gin, nw;
  logic [WORD_W-1:0]       sw_in, rot_w, sub_w, f_w;

  assign wv = win_q;

  // Only one rcon position per phase, so a single SubWord is muxed between
  // w[k+1] (P0, j=0) and w[k+3] (P2, j=2).
  assign sw_in = (phase_q == P2) ? wv[2] : wv[4];

  rotate #(.SHIFT(1), .N(4), .W(8)) u_rot (.in_i(sw_in), .out_o(rot_w));
  subword        u_sub (.in_i(rot_w),  .out_o(sub_w));
  inv_galoismult u_div (.a_i(rcon_q),  .y_o(rcon_div));

  assign f_w = sub_w ^ {rcon_q, 24'h0};

  // New word j = window word (j+2) ^ g_j(window word (j+1)); no chaining.
  always_comb begin
    for (int j = 0; j < 4; j++) gin[j] = wv[4-j];
    if (phase_q == P0)      gin[0] = f_w;
    else if (phase_q == P2) gin[2] = f_w;
    for (int j = 0; j < 4; j++) nw[3-j] = wv[3-j] ^ gin[j];
    win_d = {nw, wv[5], wv[4]};
  end

  assign step = bus.advance && vld_q && (idx_q != 4'd0) && !bus.load;

  // Sweep state: load restarts from round NROUNDS, each step moves 4 words older.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q   <= '0;
      rcon_q  <= RCON_LAST;
      phase_q <= P0;
      idx_q   <= 4'd0;
      vld_q   <= 1'b0;
    end else if (bus.load) begin
      win_q   <= bus.lastKey;
      rcon_q  <= RCON_LAST;
      phase_q <= P0;
      idx_q   <= IDX_FIRST;
      vld_q   <= 1'b1;
    end else if (step) begin
      win_q <= win_d;
      idx_q <= idx_q - 4'd1;
      case (phase_q)
        P0: begin
          phase_q <= P1;
          rcon_q  <= rcon_div;
        end
        P1: phase_q <= P2;
        default: begin
          phase_q <= P0;
          rcon_q  <= rcon_div;
        end
      endcase
    end
  end

  assign bus.roundKey = win_q[BLOCK_W-1:0];
  assign bus.roundIdx = idx_q;
  assign bus.keyValid = vld_q;
  assign bus.last     = vld_q && (idx_q == 4'd0);
endmodule

// File: tb/tb_inv_expand192.sv
// Bench for inv_expand192: forward AES-192 expansion model (log/exp-table
// S-box) gives the expected round keys; the sweep must replay them backwards.
module tb_inv_expand192;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inv_expand192_if bus();
  inv_expand192 #(.NROUNDS(12), .RCON_LAST(8'h80)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  exp_t [256];
  logic [7:0]  log_t [256];
  logic [31:0] w [52];

  typedef struct {
    bit ld;
    bit adv;
    int idx;
    bit lst;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv;
    inv = (a == 8'h00) ? 8'h00 : exp_t[(255 - int'(log_t[a])) % 255];
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic build_tables();
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = x;
      log_t[x] = 8'(i);
      x = x ^ xt(x);
    end
  endtask

  // Standard forward AES-192 key schedule into w[0..51].
  task automatic expand(input logic [191:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-6] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Rcon after s steps: steps 0,2,3,5,... (phase != P1) consume one value.
  function automatic logic [7:0] rcon_exp(input int s);
    int c;
    c = s - (s + 1) / 3;
    return (c < 8) ? 8'(8'h80 >> c) : 8'h8d;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  task automatic chk_state(input string nm, input int idx, input bit vld);
    chk({nm, ".idx"},  128'(bus.roundIdx), 128'(idx));
    chk({nm, ".vld"},  128'(bus.keyValid), 128'(vld));
    chk({nm, ".last"}, 128'(bus.last),     128'(vld && idx == 0));
    chk({nm, ".key"},  bus.roundKey,       vld ? rk(idx) : 128'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    bus.lastKey = {w[46], w[47], w[48], w[49], w[50], w[51]};
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  initial begin
    int idx;
    reset       = 1'b0;
    bus.load    = 1'b0;
    bus.advance = 1'b0;
    bus.lastKey = '0;
    build_tables();
    expand(192'h000102030405060708090a0b0c0d0e0f1011121314151617);

    #12;
    chk_state("rst", 0, 0);
    chk("rst.rcon", 128'(dut.rcon_q), 128'h80);
    reset = 1'b1;
    tick();

    // FIPS-197 key: load, 12 steps, then 5 ignored advances.
    tbl.push_back('{ld: 1'b1, adv: 1'b0, idx: 12, lst: 1'b0});
    for (int s = 1; s <= 12; s++) tbl.push_back('{ld: 1'b0, adv: 1'b1, idx: 12 - s, lst: (s == 12)});
    for (int s = 0; s < 5; s++)   tbl.push_back('{ld: 1'b0, adv: 1'b1, idx: 0, lst: 1'b1});

    bus.lastKey = {w[46], w[47], w[48], w[49], w[50], w[51]};
    foreach (tbl[i]) begin
      bus.load    = tbl[i].ld;
      bus.advance = tbl[i].adv;
      tick();
      chk_state($sformatf("tbl%0d", i), tbl[i].idx, 1'b1);
      chk($sformatf("tbl%0d.lst", i), 128'(bus.last), 128'(tbl[i].lst));
      chk($sformatf("tbl%0d.rcon", i), 128'(dut.rcon_q), 128'(rcon_exp(12 - tbl[i].idx)));
      if (i == 0)  chk("fips.rk12", bus.roundKey, 128'ha4970a331a78dc09c418c271e3a41d5d);
      if (i == 12) chk("fips.rk0",  bus.roundKey, 128'h000102030405060708090a0b0c0d0e0f);
    end
    bus.load    = 1'b0;
    bus.advance = 1'b0;

    // Load collides with advance at roundIdx 7: load wins.
    do_load();
    bus.advance = 1'b1;
    for (int s = 0; s < 5; s++) tick();
    chk_state("pre_coll", 7, 1'b1);
    bus.load = 1'b1;
    tick();
    bus.load    = 1'b0;
    bus.advance = 1'b0;
    chk_state("coll", 12, 1'b1);
    chk("coll.rcon", 128'(dut.rcon_q), 128'h80);

    // Random keys, random advance gaps.
    for (int k = 0; k < 3; k++) begin
      expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      do_load();
      idx = 12;
      chk_state($sformatf("rnd%0d.load", k), idx, 1'b1);
      for (int c = 0; c < 40; c++) begin
        bus.advance = 1'($urandom_range(0, 1));
        tick();
        if (bus.advance && idx > 0) idx--;
        chk_state($sformatf("rnd%0d.c%0d", k, c), idx, 1'b1);
        chk($sformatf("rnd%0d.c%0d.rcon", k, c), 128'(dut.rcon_q), 128'(rcon_exp(12 - idx)));
      end
      bus.advance = 1'b0;
    end

    // Asynchronous reset between clock edges in the middle of a sweep.
    do_load();
    bus.advance = 1'b1;
    for (int s = 0; s < 4; s++) tick();
    chk_state("pre_arst", 8, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    chk_state("arst", 0, 1'b0);
    #2;
    reset = 1'b1;
    for (int s = 0; s < 3; s++) tick();
    chk_state("arst.adv", 0, 1'b0);
    bus.advance = 1'b0;
    do_load();
    chk_state("arst.reload", 12, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/inv_expand192.md
Name: inv_expand192

Overview:
- AES-192 inverse key expansion for the decryption datapath.
- Takes the final 6 schedule words w[46..51] and emits round keys 12 down to 0, one per advance.
- Each step produces 4 older schedule words from a 6-word window, using w[i-6] = w[i] ^ f(w[i-1]).
- All 4 new words depend only on the current window, so there is no intra-cycle chaining; a full sweep takes 12 advances after load.

Parameters:
- NROUNDS, 12, index of the first emitted round key (round count for AES-192)
- RCON_LAST, 8'h80, Rcon value used for i=48, the first rcon-bearing word consumed

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- load  input  1  one-cycle pulse: capture lastKey and restart the sweep
- lastKey  input  192  schedule words w[46..51]; [191:160]=w46, [31:0]=w51
- advance  input  1  step to the next (older) round key
- roundKey  output  128  current round key; [127:96] is the lowest-index word
- roundIdx  output  4  index of the round key currently on roundKey (12..0)
- keyValid  output  1  roundKey holds a valid key
- last  output  1  keyValid && roundIdx==0

Behaviour:
- State registers:
  - window[191:0] holds w[k..k+5], with w[k] in [191:160].
  - rcon[7:0].
  - phase in {P0, P1, P2}.
  - roundIdx[3:0].
  - keyValid.
- Reset (reset==0, asynchronous): window=0, rcon=RCON_LAST, phase=P0, roundIdx=0, keyValid=0. Outputs are therefore roundKey=0, last=0. Reset mid-sweep aborts it immediately.
- Output mapping: roundKey = window[127:0] = w[k+2..k+5], combinational from the register.
- Load (priority over advance, accepted in any state):
  - window<=lastKey, rcon<=RCON_LAST, phase<=P0, roundIdx<=NROUNDS, keyValid<=1.
  - roundKey equals round key 12 on the cycle after load.
- Step condition: advance && keyValid && roundIdx!=0 && !load.
- Step action:
  - window <= {new[127:0], window[191:128]}, where new = w[k-4..k-1], lowest index first.
  - roundIdx decrements by 1.
  - phase P0->P1->P2->P0.
- Step is ignored when roundIdx==0 or keyValid==0. All state holds; last stays asserted until the next load.
- Word generation in every phase: new word j (j=0..3) = window word (j+2) ^ g_j(window word (j+1)).
- g_j is the identity except at one rcon position per phase:
  - P0: j=0 uses SubWord(RotWord(w[k+1])) ^ {rcon,24'h0}.
  - P1: no rcon position.
  - P2: j=2 uses SubWord(RotWord(w[k+3])) ^ {rcon,24'h0}.
- Rcon update:
  - On a step in P0 or P2, rcon <= rcon/x in GF(2^8): (rcon[0] ? (rcon^8'h1b)>>1 | 8'h80 : rcon>>1).
  - rcon holds on a P1 step.
  - Sequence consumed: 80,40,20,10,08,04,02,01.
- On the final step (phase P2, k=2 -> -2), window words w[-2], w[-1] are don't-care and are never exposed on roundKey.
- Exactly one SubWord instance is used per cycle.
- No combinational path from advance or load to roundKey.

Decomposition:
- Shared package aes_key_pkg:
  - phase enum typedef (P0, P1, P2).
  - RCON_LAST constant.
  - AES-192 word and block width constants.
- Reuse the existing codebase subword and rotate(1,4,8) modules.
- One new sub-module, inv_galoismult: 8-bit GF(2^8) divide-by-x, the inverse of galoismult.

Test Plan:
- FIPS-197 C.2 key 000102...1617: forward-expand to get w46..w51, then load.
  - Cycle after load: roundKey=a4970a331a78dc09c418c271e3a41d5d, roundIdx=12, keyValid=1.
- Same load, then advance held high 12 cycles.
  - Each roundKey equals the forward expander's round key in reverse order.
  - After advance 12: roundKey=000102030405060708090a0b0c0d0e0f, roundIdx=0, last=1.
- After reaching roundIdx=0, hold advance high 5 more cycles -> roundKey, rcon, roundIdx unchanged; last stays 1.
- Advance deasserted randomly between steps -> keys still emerge in the same order and hold between advances; rcon follows 80,40,...,01 only on P0/P2 steps.
- Assert load together with advance at roundIdx=7 -> load wins; next cycle roundIdx=12 with round key 12.
- Drive reset low asynchronously mid-sweep (between clock edges) -> keyValid=0, roundKey=0 immediately; advance ignored until load.
